// File: rtl/cpu64_l2_pkg.sv
// Shared L2 definitions: TileLink probe cap encodings and the probe FSM state type.
package cpu64_l2_pkg;

  localparam logic [1:0] CAP_TOT = 2'd0;
  localparam logic [1:0] CAP_TOB = 2'd1;
  localparam logic [1:0] CAP_TON = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } probe_state_e;

endpackage

// File: rtl/cpu64_l2_prio_enc.sv
// Lowest-set-bit priority encoder; also used by the MSHR allocator.
module cpu64_l2_prio_enc #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu64_l2_probe_ctrl.sv
// L2 probe controller: one B-channel Probe per targeted core, collects C-channel
// ProbeAck/ProbeAckData, forwards acks to the MSHR and reports done/dirty.
module cpu64_l2_probe_ctrl
  import cpu64_l2_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int CORES  = 4,
  parameter int CORE_W = $clog2(CORES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              start_ready_o,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [CORES-1:0]  start_mask_i,
  input  logic [1:0]        start_param_i,
  output logic              b_valid_o,
  output logic [CORE_W-1:0] b_core_o,
  output logic [ADDR_W-1:0] b_addr_o,
  output logic [1:0]        b_param_o,
  input  logic              b_ready_i,
  input  logic              c_valid_i,
  input  logic [CORE_W-1:0] c_core_i,
  input  logic              c_data_i,
  output logic              c_ready_o,
  output logic              probe_ack_o,
  output logic [CORE_W-1:0] probe_ack_id_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              dirty_o,
  output logic              spurious_o
);

  localparam logic [CORE_W:0] LP_CORES = (CORE_W + 1)'(CORES);

  probe_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_param;
  logic [CORES-1:0]  r_to_send, r_to_ack;
  logic              r_dirty, r_ack_pulse, r_spur;
  logic [CORE_W-1:0] r_ack_id;

  logic [CORE_W-1:0] w_lo_idx;
  logic              w_lo_found;
  logic              w_start_acc, w_b_fire, w_c_fire, w_c_in_range, w_c_ok, w_c_spur;
  logic [CORES-1:0]  w_send_clr, w_ack_clr, w_to_send_nxt, w_to_ack_nxt;

  cpu64_l2_prio_enc #(.N(CORES), .W(CORE_W)) u_prio_enc (
    .i_vec   (r_to_send),
    .o_idx   (w_lo_idx),
    .o_found (w_lo_found)
  );

  assign w_start_acc  = start_i && (r_state == ST_IDLE);
  assign w_b_fire     = (r_state == ST_ISSUE) && w_lo_found && b_ready_i;
  assign w_c_fire     = c_valid_i && c_ready_o;
  assign w_c_in_range = ({1'b0, c_core_i} < LP_CORES);
  // An ack only counts for a core whose probe went out in an earlier cycle.
  assign w_c_ok       = w_c_fire && w_c_in_range && r_to_ack[c_core_i] && !r_to_send[c_core_i];
  assign w_c_spur     = w_c_fire && !w_c_ok;

  assign w_send_clr    = w_b_fire ? (CORES'(1) << w_lo_idx) : '0;
  assign w_ack_clr     = w_c_ok   ? (CORES'(1) << c_core_i) : '0;
  assign w_to_send_nxt = r_to_send & ~w_send_clr;
  assign w_to_ack_nxt  = r_to_ack  & ~w_ack_clr;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples its inputs from the same edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    start_ready_o = 1'b0;
    busy_o        = 1'b1;
    b_valid_o     = 1'b0;
    c_ready_o     = 1'b0;
    done_o        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        start_ready_o = 1'b1;
        busy_o        = 1'b0;
        if (start_i) begin
          w_state_nxt = (start_mask_i != '0) ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        b_valid_o = 1'b1;
        c_ready_o = 1'b1;
        if (w_to_send_nxt == '0) begin
          w_state_nxt = (w_to_ack_nxt == '0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        c_ready_o = 1'b1;
        if (w_to_ack_nxt == '0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_param     <= '0;
      r_to_send   <= '0;
      r_to_ack    <= '0;
      r_dirty     <= 1'b0;
      r_ack_pulse <= 1'b0;
      r_ack_id    <= '0;
      r_spur      <= 1'b0;
    end else begin
      r_ack_pulse <= w_c_ok;
      r_ack_id    <= w_c_ok ? c_core_i : '0;
      r_spur      <= w_c_spur;
      if (w_start_acc) begin
        r_addr    <= start_addr_i;
        r_param   <= start_param_i;
        r_to_send <= start_mask_i;
        r_to_ack  <= start_mask_i;
        r_dirty   <= 1'b0;
      end else begin
        r_to_send <= w_to_send_nxt;
        r_to_ack  <= w_to_ack_nxt;
        if (w_c_ok && c_data_i) begin
          r_dirty <= 1'b1;
        end
      end
    end
  end

  assign b_core_o       = w_lo_idx;
  assign b_addr_o       = r_addr;
  assign b_param_o      = r_param;
  assign probe_ack_o    = r_ack_pulse;
  assign probe_ack_id_o = r_ack_id;
  assign spurious_o     = r_spur;
  assign dirty_o        = r_dirty;

endmodule

// File: tb/tb_cpu64_l2_probe_ctrl.sv
// Self-checking bench for cpu64_l2_probe_ctrl: directed table, corner sequences and
// randomized rounds compared against a set-based reference model.
module tb_cpu64_l2_probe_ctrl;
  import cpu64_l2_pkg::*;

  localparam int ADDR_W = 64;
  localparam int CORES  = 4;
  localparam int CORE_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i, start_ready_o;
  logic [ADDR_W-1:0] start_addr_i;
  logic [CORES-1:0]  start_mask_i;
  logic [1:0]        start_param_i;
  logic              b_valid_o, b_ready_i;
  logic [CORE_W-1:0] b_core_o;
  logic [ADDR_W-1:0] b_addr_o;
  logic [1:0]        b_param_o;
  logic              c_valid_i, c_data_i, c_ready_o;
  logic [CORE_W-1:0] c_core_i;
  logic              probe_ack_o;
  logic [CORE_W-1:0] probe_ack_id_o;
  logic              busy_o, done_o, dirty_o, spurious_o;

  always #5 clk = ~clk;

  cpu64_l2_probe_ctrl #(.ADDR_W(ADDR_W), .CORES(CORES), .CORE_W(CORE_W)) dut (
    .clk(clk), .rst(rst),
    .start_i(start_i), .start_ready_o(start_ready_o), .start_addr_i(start_addr_i),
    .start_mask_i(start_mask_i), .start_param_i(start_param_i),
    .b_valid_o(b_valid_o), .b_core_o(b_core_o), .b_addr_o(b_addr_o),
    .b_param_o(b_param_o), .b_ready_i(b_ready_i),
    .c_valid_i(c_valid_i), .c_core_i(c_core_i), .c_data_i(c_data_i), .c_ready_o(c_ready_o),
    .probe_ack_o(probe_ack_o), .probe_ack_id_o(probe_ack_id_o),
    .busy_o(busy_o), .done_o(done_o), .dirty_o(dirty_o), .spurious_o(spurious_o)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [63:0] addr;
    logic [1:0]  prm;
    logic [3:0]  dmask;
    int          n;
    int          order[4];
    logic        dirty;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: sets of cores still to probe / still to ack, plus round phase.
  bit          m_idle, m_done, m_pulse, m_spur, m_dirty;
  bit [3:0]    m_send, m_ack;
  int          m_pid;
  logic [63:0] m_addr;
  logic [1:0]  m_param;

  int obs_probes[$];
  int obs_acks[$];
  int pend[$];
  int n_spur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int lowest(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_done = 0; m_pulse = 0; m_spur = 0; m_dirty = 0;
    m_send = '0; m_ack = '0; m_pid = 0; m_addr = '0; m_param = '0;
  endtask

  // One clock cycle: compare outputs, apply inputs, advance the model, wait a cycle.
  task automatic cycle(input bit st, input logic [3:0] mask, input logic [63:0] addr,
                       input logic [1:0] prm, input bit br, input bit cv, input int cc,
                       input bit cd);
    bit active, bv, hs, fire, ok;
    int lo;
    active = !m_idle && !m_done;
    bv     = active && (m_send != 0);
    lo     = lowest(m_send);
    check("start_ready", start_ready_o, m_idle);
    check("busy", busy_o, !m_idle);
    check("done", done_o, m_done);
    check("b_valid", b_valid_o, bv);
    check("c_ready", c_ready_o, active);
    check("probe_ack", probe_ack_o, m_pulse);
    check("spurious", spurious_o, m_spur);
    if (m_pulse) check("probe_ack_id", probe_ack_id_o, m_pid);
    if (bv) begin
      check("b_core", b_core_o, lo);
      check("b_addr", b_addr_o, m_addr);
      check("b_param", b_param_o, m_param);
    end
    if (m_idle || m_done) check("dirty", dirty_o, m_dirty);
    if (probe_ack_o) obs_acks.push_back(int'(probe_ack_id_o));
    if (spurious_o) n_spur++;
    if (b_valid_o && br) begin
      obs_probes.push_back(int'(b_core_o));
      pend.push_back(int'(b_core_o));
    end

    start_i = st; start_mask_i = mask; start_addr_i = addr; start_param_i = prm;
    b_ready_i = br; c_valid_i = cv; c_core_i = CORE_W'(cc); c_data_i = cd;

    hs   = bv && br;
    fire = active && cv;
    ok   = fire && (cc < CORES) && m_ack[cc] && !m_send[cc];
    m_pulse = ok;
    m_pid   = cc;
    m_spur  = fire && !ok;
    if (hs) m_send[lo] = 1'b0;
    if (ok) begin
      m_ack[cc] = 1'b0;
      if (cd) m_dirty = 1'b1;
    end
    if (m_idle) begin
      if (st) begin
        m_idle = 0; m_send = mask; m_ack = mask; m_addr = addr; m_param = prm;
        m_dirty = 0; m_done = (mask == 0);
      end
    end else if (m_done) begin
      m_done = 0; m_idle = 1;
    end else if (m_send == 0 && m_ack == 0) begin
      m_done = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    cycle(0, 4'h0, 64'h0, 2'd0, 0, 0, 0, 0);
  endtask

  // Full round: always ready on B, ack each probed core the cycle after its probe.
  task automatic run_vec(input vec_t v, input string tag);
    int c;
    obs_probes.delete(); pend.delete();
    cycle(1, v.mask, v.addr, v.prm, 0, 0, 0, 0);
    for (int k = 0; k < 30 && !done_o; k++) begin
      if (pend.size() > 0) begin
        c = pend.pop_front();
        cycle(0, 4'h0, 64'h0, 2'd0, 1, 1, c, v.dmask[c]);
      end else begin
        cycle(0, 4'h0, 64'h0, 2'd0, 1, 0, 0, 0);
      end
    end
    check({tag, "_done"}, done_o, 1'b1);
    check({tag, "_dirty"}, dirty_o, v.dirty);
    check({tag, "_nprobe"}, obs_probes.size(), v.n);
    for (int i = 0; i < v.n && i < obs_probes.size(); i++)
      check({tag, "_order"}, obs_probes[i], v.order[i]);
    idle_cyc();
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{4'b1101, 64'h1000,           CAP_TON, 4'b0001, 3, '{0, 2, 3, 0}, 1'b1};
    tbl[1] = '{4'b0010, 64'hdead_beef_0040, CAP_TOB, 4'b0000, 1, '{1, 0, 0, 0}, 1'b0};
    tbl[2] = '{4'b1111, 64'h8000_0000_0000, CAP_TOT, 4'b1000, 4, '{0, 1, 2, 3}, 1'b1};
    tbl[3] = '{4'b0000, 64'h0000_0000_2000, CAP_TON, 4'b0000, 0, '{0, 0, 0, 0}, 1'b0};
    tbl[4] = '{4'b1010, 64'h0123_4567_89c0, CAP_TOB, 4'b0010, 2, '{1, 3, 0, 0}, 1'b1};

    rst = 1'b1;
    start_i = 0; start_mask_i = '0; start_addr_i = '0; start_param_i = '0;
    b_ready_i = 0; c_valid_i = 0; c_core_i = '0; c_data_i = 0;
    model_reset();
    n_spur = 0;
    repeat (2) @(negedge clk);
    check("rst_start_ready", start_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_b_valid", b_valid_o, 1'b0);
    check("rst_c_ready", c_ready_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_probe_ack", probe_ack_o, 1'b0);
    check("rst_dirty", dirty_o, 1'b0);
    check("rst_spurious", spurious_o, 1'b0);
    rst = 1'b0;
    idle_cyc();

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Probes to 0,2,3 back to back, then acks 2, 0 (dirty), 3.
    obs_probes.delete(); obs_acks.delete();
    cycle(1, 4'b1101, 64'h1000, CAP_TON, 0, 0, 0, 0);
    repeat (3) cycle(0, 4'h0, 64'h0, 2'd0, 1, 0, 0, 0);
    cycle(0, 4'h0, 64'h0, 2'd0, 0, 1, 2, 0);
    cycle(0, 4'h0, 64'h0, 2'd0, 0, 1, 0, 1);
    cycle(0, 4'h0, 64'h0, 2'd0, 0, 1, 3, 0);
    check("seq1_done", done_o, 1'b1);
    check("seq1_dirty", dirty_o, 1'b1);
    idle_cyc();
    check("seq1_nacks", obs_acks.size(), 3);
    if (obs_acks.size() == 3) begin
      check("seq1_ack0", obs_acks[0], 2);
      check("seq1_ack1", obs_acks[1], 0);
      check("seq1_ack2", obs_acks[2], 3);
    end

    // B backpressure: core 0 held for 3 cycles, core 2 only after the handshake.
    cycle(1, 4'b0101, 64'h4000, CAP_TOB, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 4'h0, 64'h0, 2'd0, 0, 0, 0, 0);
      check("stall_core", b_core_o, 0);
      check("stall_addr", b_addr_o, 64'h4000);
      check("stall_param", b_param_o, CAP_TOB);
    end
    cycle(0, 4'h0, 64'h0, 2'd0, 1, 0, 0, 0);
    check("stall_next_core", b_core_o, 2);
    cycle(0, 4'h0, 64'h0, 2'd0, 1, 1, 0, 0);
    cycle(0, 4'h0, 64'h0, 2'd0, 0, 1, 2, 0);
    check("stall_done", done_o, 1'b1);
    check("stall_dirty", dirty_o, 1'b0);
    idle_cyc();

    // Spurious acks: unsent core, unmasked core, own-handshake cycle, repeated ack.
    n_spur = 0; obs_acks.delete();
    cycle(1, 4'b0101, 64'h2000, CAP_TOB, 0, 0, 0, 0);
    cycle(0, 4'h0, 64'h0, 2'd0, 0, 1, 2, 0);
    cycle(0, 4'h0, 64'h0, 2'd0, 1, 1, 1, 0);
    cycle(0, 4'h0, 64'h0, 2'd0, 0, 1, 0, 0);
    cycle(0, 4'h0, 64'h0, 2'd0, 1, 1, 2, 1);
    cycle(0, 4'h0, 64'h0, 2'd0, 0, 1, 0, 1);
    check("spur_not_done", done_o, 1'b0);
    cycle(0, 4'h0, 64'h0, 2'd0, 0, 1, 2, 0);
    check("spur_done", done_o, 1'b1);
    check("spur_dirty", dirty_o, 1'b0);
    idle_cyc();
    check("spur_count", n_spur, 4);
    check("spur_nacks", obs_acks.size(), 2);

    // Reset while waiting on core 3's ack, then a normal round.
    cycle(1, 4'b1000, 64'h3000, CAP_TON, 0, 0, 0, 0);
    cycle(0, 4'h0, 64'h0, 2'd0, 1, 0, 0, 0);
    idle_cyc();
    check("prerst_wait", c_ready_o && !b_valid_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_start_ready", start_ready_o, 1'b1);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_c_ready", c_ready_o, 1'b0);
    check("midrst_done", done_o, 1'b0);
    b_ready_i = 0; c_valid_i = 1; c_core_i = 2'd3; start_i = 0;
    @(negedge clk);
    rst = 1'b0;
    c_valid_i = 0;
    model_reset();
    repeat (2) idle_cyc();
    run_vec(tbl[0], "postrst");

    // Randomized rounds with random backpressure, acks, data and ignored starts.
    for (int r = 0; r < 40; r++) begin
      pend.delete();
      repeat ($urandom_range(0, 2)) idle_cyc();
      cycle(1, 4'($urandom), {$urandom, $urandom}, 2'($urandom_range(0, 2)), 0, 0, 0, 0);
      for (int k = 0; k < 200 && !m_idle; k++)
        cycle($urandom_range(0, 3) == 0, 4'($urandom), {$urandom, $urandom},
              2'($urandom_range(0, 2)), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      check("rnd_round_end", busy_o, 1'b0);
    end
    idle_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
